// File: rtl/mod_issue_ctrl.sv
// Upstream issue controller for the iterative 32-bit modulo stage.
// Buffers operand pairs in a small FIFO, screens each head pair, issues one
// pair at a time to the modulo stage, waits a fixed budget and returns the
// remainder (or an error flag) on a valid/ready result port.

package mod_issue_ctrl_pkg;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } pair_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ERR   = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;
endpackage

module mod_issue_ctrl
  import mod_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_ITER = 64,
  parameter int unsigned SLACK    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              mod_reset,
  output logic [DATA_W-1:0] mod_a,
  output logic [DATA_W-1:0] mod_b,
  input  logic [DATA_W-1:0] mod_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rem,
  output logic              out_err,
  output logic              busy
);

  localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
  localparam int unsigned WAIT_LOAD = MAX_ITER + SLACK - 1;
  localparam int unsigned WAIT_W    = $clog2(WAIT_LOAD + 1);
  localparam int unsigned PROD_W    = 2 * DATA_W;

  // FIFO storage and bookkeeping
  pair_t              fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               push_c;
  logic               pop_c;
  logic               nonempty_c;
  pair_t              head_c;
  pair_t              in_pair_c;

  // Screening
  logic [PROD_W-1:0]  budget_c;
  logic               reject_c;

  // FSM and datapath registers
  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mod_reset_q, mod_reset_d;
  logic [DATA_W-1:0]  mod_a_q, mod_a_d;
  logic [DATA_W-1:0]  mod_b_q, mod_b_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_rem_q, out_rem_d;
  logic               out_err_q, out_err_d;
  logic               in_ready_q;
  logic               busy_q;

  assign in_pair_c  = '{a: in_a, b: in_b};
  assign push_c     = in_valid & in_ready_q;
  assign nonempty_c = (count_q != '0);
  assign head_c     = fifo_mem[rd_ptr_q];

  // Reject b==0 and pairs whose quotient would exceed the fixed wait budget
  assign budget_c = PROD_W'(head_c.b) * PROD_W'(MAX_ITER);
  assign reject_c = (head_c.b == '0) | ({{DATA_W{1'b0}}, head_c.a} >= budget_c);

  // FIFO payload write; storage needs no reset, validity lives in count_q
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_mem[wr_ptr_q] <= in_pair_c;
    end
  end

  // FIFO pointer and occupancy next-state; simultaneous push/pop keeps count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (nonempty_c) begin
          state_d = reject_c ? ST_ERR : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = ST_HOLD;
        end
      end
      ST_ERR:  state_d = ST_HOLD;
      ST_HOLD: begin
        if (out_valid_q & out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output logic: pop strobe and next values of the registered datapath
  always_comb begin
    pop_c       = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    mod_reset_d = mod_reset_q;
    mod_a_d     = mod_a_q;
    mod_b_d     = mod_b_q;
    out_valid_d = out_valid_q;
    out_rem_d   = out_rem_q;
    out_err_d   = out_err_q;
    case (state_q)
      ST_IDLE: begin
        mod_reset_d = 1'b1;
        if (nonempty_c) begin
          pop_c   = 1'b1;
          mod_a_d = head_c.a;
          mod_b_d = head_c.b;
        end
      end
      ST_ISSUE: begin
        // Operands have been stable under reset for one cycle; release the stage
        wait_cnt_d  = WAIT_W'(WAIT_LOAD);
        mod_reset_d = 1'b0;
      end
      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          out_rem_d   = mod_out;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          mod_reset_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      ST_ERR: begin
        out_rem_d   = '0;
        out_err_d   = 1'b1;
        out_valid_d = 1'b1;
        mod_reset_d = 1'b1;
      end
      ST_HOLD: begin
        if (out_valid_q & out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: begin
        mod_reset_d = 1'b1;
      end
    endcase
  end

  // Datapath, FIFO bookkeeping and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_cnt_q  <= '0;
      mod_reset_q <= 1'b1;
      mod_a_q     <= '0;
      mod_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_rem_q   <= '0;
      out_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_cnt_q  <= wait_cnt_d;
      mod_reset_q <= mod_reset_d;
      mod_a_q     <= mod_a_d;
      mod_b_q     <= mod_b_d;
      out_valid_q <= out_valid_d;
      out_rem_q   <= out_rem_d;
      out_err_q   <= out_err_d;
      in_ready_q  <= (count_d != CNT_W'(DEPTH));
      busy_q      <= (state_d != ST_IDLE) | (count_d != '0);
    end
  end

  assign in_ready  = in_ready_q;
  assign mod_reset = mod_reset_q;
  assign mod_a     = mod_a_q;
  assign mod_b     = mod_b_q;
  assign out_valid = out_valid_q;
  assign out_rem   = out_rem_q;
  assign out_err   = out_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mod_issue_ctrl.sv
// Bench for mod_issue_ctrl: directed vector table, hand sequences for
// back-pressure and mid-operation reset, and randomized traffic checked
// against a quotient/remainder reference model through an in-order scoreboard.

module tb_mod_issue_ctrl;
  localparam int unsigned MAX_ITER = 64;
  localparam int unsigned SLACK    = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        mod_reset;
  logic [31:0] mod_a, mod_b, mod_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rem;
  logic        out_err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;

  typedef struct {
    logic [31:0] rem;
    logic        err;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rem;
    logic        err;
  } vec_t;

  res_t exp_q[$];

  mod_issue_ctrl #(.DEPTH(4), .MAX_ITER(MAX_ITER), .SLACK(SLACK)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mod_reset (mod_reset),
    .mod_a     (mod_a),
    .mod_b     (mod_b),
    .mod_out   (mod_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rem   (out_rem),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural modulo stage: one subtraction per cycle while out of reset
  logic [31:0] mod_r;
  always @(posedge clk) begin
    if (mod_reset) mod_r <= mod_a;
    else if (mod_b != 32'd0 && mod_r >= mod_b) mod_r <= mod_r - mod_b;
  end
  assign mod_out = mod_r;

  function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    if (b == 32'd0) begin
      r.err = 1'b1;
    end else begin
      r.err = ((a / b) >= MAX_ITER);
    end
    r.rem = r.err ? 32'd0 : (a % b);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // In-order scoreboard; reset discards everything in flight
  always @(posedge clk) begin
    res_t e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got rem 0x%0h err %0d expected no result", out_rem, out_err);
        end else begin
          e = exp_q.pop_front();
          chk("sb_rem", out_rem, e.rem);
          chk("sb_err", 32'(out_err), 32'(e.err));
        end
        rx_cnt++;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_a, in_b));
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(in_ready), 32'd1);
    if (!in_ready) return;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Single pair on an idle controller: latency counted in edges after the push edge
  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_rem, input logic exp_err, input string tag);
    int          n;
    logic        saw_low;
    logic [31:0] held;
    push(a, b);
    n       = 0;
    saw_low = 1'b0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!mod_reset) saw_low = 1'b1;
    end while (!out_valid && n < 300);
    chk({tag, "_latency"}, 32'(n), exp_err ? 32'd2 : 32'(MAX_ITER + SLACK + 2));
    chk({tag, "_rem"}, out_rem, exp_rem);
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
    chk({tag, "_modrst_released"}, 32'(saw_low), 32'(!exp_err));
    held = out_rem;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_hold_rem"}, out_rem, held);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
  endtask

  vec_t vecs[13];
  vec_t t5[6];

  initial begin
    int base;
    int cnt;

    vecs[0]  = '{32'd100,        32'd7,          32'd2,          1'b0};
    vecs[1]  = '{32'd5,          32'd9,          32'd5,          1'b0};
    vecs[2]  = '{32'd0,          32'd3,          32'd0,          1'b0};
    vecs[3]  = '{32'd123,        32'd0,          32'd0,          1'b1};
    vecs[4]  = '{32'd1000,       32'd1,          32'd0,          1'b1};
    vecs[5]  = '{32'd640,        32'd10,         32'd0,          1'b1};
    vecs[6]  = '{32'd639,        32'd10,         32'd9,          1'b0};
    vecs[7]  = '{32'd319,        32'd5,          32'd4,          1'b0};
    vecs[8]  = '{32'd320,        32'd5,          32'd0,          1'b1};
    vecs[9]  = '{32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  1'b0};
    vecs[10] = '{32'hFFFF_FFFF,  32'h0400_0000,  32'h03FF_FFFF,  1'b0};
    vecs[11] = '{32'd63,         32'd1,          32'd0,          1'b0};
    vecs[12] = '{32'd64,         32'd1,          32'd0,          1'b1};

    t5[0] = '{32'd100, 32'd7,  32'd0, 1'b0};
    t5[1] = '{32'd17,  32'd5,  32'd0, 1'b0};
    t5[2] = '{32'd9,   32'd0,  32'd0, 1'b0};
    t5[3] = '{32'd77,  32'd77, 32'd0, 1'b0};
    t5[4] = '{32'd1,   32'd2,  32'd0, 1'b0};
    t5[5] = '{32'd640, 32'd10, 32'd0, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_mod_reset", 32'(mod_reset), 32'd1);
    chk("rst_mod_a",     mod_a,          32'd0);
    chk("rst_mod_b",     mod_b,          32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_rem",   out_rem,        32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors, one pair at a time on an idle controller
    for (int i = 0; i < 13; i++) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].rem, vecs[i].err, $sformatf("vec%0d", i));
    end

    // Back-pressure: one pair in flight plus a full FIFO blocks the producer
    base = rx_cnt;
    for (int i = 0; i < 5; i++) push(t5[i].a, t5[i].b);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_busy",     32'(busy),     32'd1);
    fork
      push(t5[5].a, t5[5].b);
      begin
        int g;
        g = 0;
        @(negedge clk);
        out_ready = 1'b1;
        while (rx_cnt < base + 6 && g < 2000) begin
          @(posedge clk);
          g++;
        end
      end
    join
    repeat (100) @(posedge clk);
    #1;
    chk("full_result_count", 32'(rx_cnt - base), 32'd6);
    chk("full_drained_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;

    // Reset during WAIT with another pair queued behind it
    push(32'd100, 32'd7);
    repeat (10) @(posedge clk);
    push(32'd1, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_mod_reset", 32'(mod_reset), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy",      32'(busy),      32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    repeat (150) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    chk("midrst_no_result", 32'(cnt), 32'd0);
    out_ready = 1'b0;
    run_one(32'd50, 32'd8, 32'd2, 1'b0, "after_rst");

    // Randomized traffic with random producer gaps and consumer stalls
    base = rx_cnt;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          logic [31:0] a, b;
          case ($urandom_range(0, 3))
            0: begin b = 32'd0; a = $urandom; end
            1: begin b = $urandom_range(1, 1000); a = $urandom_range(0, b * 32'd70); end
            2: begin b = $urandom; a = $urandom; end
            default: begin
              b = $urandom_range(1, 20);
              a = b * 32'd64 - 32'($urandom_range(0, 1));
            end
          endcase
          repeat ($urandom_range(0, 3)) @(negedge clk);
          push(a, b);
        end
      end
      begin
        int g;
        g = 0;
        while (rx_cnt < base + 24 && g < 30000) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
          g++;
        end
      end
    join
    out_ready = 1'b0;
    chk("rand_result_count", 32'(rx_cnt - base), 32'd24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
